// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage.
//
// Owns the PC and issues word reads to instruction memory over a req/ack
// handshake. It presents the fetched instruction, PC+4 and the J-type jump
// target to the IF/ID register. A one-entry skid buffer absorbs a response
// that arrives while IF/ID is stalled, so no word is lost or duplicated.
// A redirect restarts fetch at a new PC. If a request is still in flight
// when the redirect arrives, its response is drained and dropped.
//
// Optional build macro:
//   FETCH_JUMP_PREDECODE_EN - J/JAL words steer the next fetch to their target
//                             and raise pred_jump_o with that output.
//
// Ports:
//   clock          in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   stall_i        in   IF/ID does not consume the outputs this cycle
//   redirect_i     in   flush and restart fetch at redirect_pc_i
//   redirect_pc_i  in   [31:0] redirect target (word aligned)
//   imem_req_o     out  read request
//   imem_addr_o    out  [31:0] read address, stable until ack
//   imem_ack_i     in   read data valid while imem_req_o=1
//   imem_rdata_i   in   [31:0] read data
//   instruction_o  out  [31:0] fetched word or NOP_INSTR
//   pc_incr_o      out  [31:0] fetched PC + 4
//   pc_jump_o      out  [31:0] {pc_incr_o[31:28], instruction_o[25:0], 2'b00}
//   valid_o        out  outputs hold a real instruction
//   pred_jump_o    out  fetch-side jump taken for the current output
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | just out of reset, no request yet
// REQ     | request for pc outstanding
// HOLD    | skid buffer full, waiting for IF/ID to accept the outputs
// DISCARD | draining a stale request after a redirect; data is dropped

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_incr_o,
    output logic [31:0] pc_jump_o,
    output logic        valid_o,
    output logic        pred_jump_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        req, req_n;
    logic [31:0] addr, addr_n;
    logic [31:0] instr, instr_n;
    logic [31:0] incr, incr_n;
    logic [31:0] jump, jump_n;
    logic        valid, valid_n;
    logic        pred, pred_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_incr, skid_incr_n;
    logic        skid_pred, skid_pred_n;

    logic [31:0] fetch_incr;
    logic [31:0] fetch_next;
    logic        is_jump;
    logic        slot_free;

    assign fetch_incr = pc + 32'd4;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign is_jump = (imem_rdata_i[31:26] == 6'b000010) ||
                     (imem_rdata_i[31:26] == 6'b000011);
`else
    assign is_jump = 1'b0;
`endif

    assign fetch_next = is_jump ? {fetch_incr[31:28], imem_rdata_i[25:0], 2'b00}
                                : fetch_incr;

    // The output slot can take a new word if it is empty or being consumed now.
    assign slot_free = !valid || !stall_i;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_n        = req;
        addr_n       = addr;
        instr_n      = instr;
        incr_n       = incr;
        jump_n       = jump;
        valid_n      = valid;
        pred_n       = pred;
        skid_instr_n = skid_instr;
        skid_incr_n  = skid_incr;
        skid_pred_n  = skid_pred;

        if (redirect_i) begin
            pc_n    = redirect_pc_i;
            valid_n = 1'b0;
            instr_n = NOP_INSTR;
            incr_n  = 32'd0;
            jump_n  = 32'd0;
            pred_n  = 1'b0;
            req_n   = 1'b1;
            // An unfinished request must still be drained, so its address is
            // held until the memory acks it. A completed one is simply dropped.
            if ((state == REQ || state == DISCARD) && !imem_ack_i) begin
                state_n = DISCARD;
            end else begin
                state_n = REQ;
                addr_n  = redirect_pc_i;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = pc;
                end
                REQ: begin
                    if (imem_ack_i) begin
                        pc_n = fetch_next;
                        if (slot_free) begin
                            instr_n = imem_rdata_i;
                            incr_n  = fetch_incr;
                            jump_n  = {fetch_incr[31:28], imem_rdata_i[25:0], 2'b00};
                            valid_n = 1'b1;
                            pred_n  = is_jump;
                            addr_n  = fetch_next;
                        end else begin
                            skid_instr_n = imem_rdata_i;
                            skid_incr_n  = fetch_incr;
                            skid_pred_n  = is_jump;
                            state_n      = HOLD;
                            req_n        = 1'b0;
                        end
                    end else if (!stall_i) begin
                        valid_n = 1'b0;
                        instr_n = NOP_INSTR;
                        jump_n  = {incr[31:28], NOP_INSTR[25:0], 2'b00};
                        pred_n  = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        instr_n = skid_instr;
                        incr_n  = skid_incr;
                        jump_n  = {skid_incr[31:28], skid_instr[25:0], 2'b00};
                        valid_n = 1'b1;
                        pred_n  = skid_pred;
                        state_n = REQ;
                        req_n   = 1'b1;
                        addr_n  = pc;
                    end
                end
                DISCARD: begin
                    if (imem_ack_i) begin
                        state_n = REQ;
                        req_n   = 1'b1;
                        addr_n  = pc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req        <= 1'b0;
            addr       <= 32'd0;
            instr      <= NOP_INSTR;
            incr       <= 32'd0;
            jump       <= 32'd0;
            valid      <= 1'b0;
            pred       <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_incr  <= 32'd0;
            skid_pred  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req        <= req_n;
            addr       <= addr_n;
            instr      <= instr_n;
            incr       <= incr_n;
            jump       <= jump_n;
            valid      <= valid_n;
            pred       <= pred_n;
            skid_instr <= skid_instr_n;
            skid_incr  <= skid_incr_n;
            skid_pred  <= skid_pred_n;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = addr;
    assign instruction_o = instr;
    assign pc_incr_o     = incr;
    assign pc_jump_o     = jump;
    assign valid_o       = valid;
    assign pred_jump_o   = pred;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_incr_o;
    logic [31:0] pc_jump_o;
    logic        valid_o;
    logic        pred_jump_o;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instruction_o (instruction_o),
        .pc_incr_o     (pc_incr_o),
        .pc_jump_o     (pc_jump_o),
        .valid_o       (valid_o),
        .pred_jump_o   (pred_jump_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the stream of words IF/ID must consume, in order.
    logic [31:0] exp_pc;
    int          consumed;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0800_0080 : (a | 32'hA000_0000);
    endfunction

    function automatic logic is_j(input logic [31:0] w);
`ifdef FETCH_JUMP_PREDECODE_EN
        return (w[31:26] == 6'b000010) || (w[31:26] == 6'b000011);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] jtarget(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        return {p4[31:28], w[25:0], 2'b00};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
        return is_j(w) ? jtarget(pc, w) : pc + 32'd4;
    endfunction

    task automatic model_reset();
        exp_pc   = RESET_PC;
        prev_req = 1'b0;
        prev_ack = 1'b0;
    endtask

    // Called just after a falling edge: drive inputs for the next rising edge,
    // score what IF/ID consumes on that edge, then advance one cycle.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic ak);
        logic [31:0] w;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_ack_i    = ak & imem_req_o;
        imem_rdata_i  = imem_ack_i ? mem(imem_addr_o) : $urandom;
        if (rd) begin
            exp_pc = rpc;
        end else if (valid_o && !st) begin
            w = mem(exp_pc);
            chk("instr", instruction_o, w);
            chk("pc_incr", pc_incr_o, exp_pc + 32'd4);
            chk("pc_jump", pc_jump_o, jtarget(exp_pc, w));
            chk("pred_jump", {31'd0, pred_jump_o}, {31'd0, is_j(w)});
            consumed++;
            exp_pc = next_pc(exp_pc, w);
        end
        prev_req  = imem_req_o;
        prev_ack  = imem_ack_i;
        prev_addr = imem_addr_o;
        @(posedge clock);
        @(negedge clock);
        if (prev_req && !prev_ack) begin
            chk("req_hold", {31'd0, imem_req_o}, 32'd1);
            chk("addr_hold", imem_addr_o, prev_addr);
        end
        if (!valid_o) chk("bubble_nop", instruction_o, NOP_INSTR);
    endtask

    initial begin
        logic [31:0] rpc;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'd0;
        consumed      = 0;
        model_reset();
        repeat (2) @(negedge clock);

        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_instr", instruction_o, NOP_INSTR);
        chk("rst_incr", pc_incr_o, 32'd0);
        chk("rst_jump", pc_jump_o, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_pred", {31'd0, pred_jump_o}, 32'd0);
        rst_n = 1'b1;

        // Streaming with zero-wait ack.
        cycle(0, 0, 0, 0);
        chk("t1_req", {31'd0, imem_req_o}, 32'd1);
        chk("t1_addr0", imem_addr_o, RESET_PC);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1);
            chk("t1_valid", {31'd0, valid_o}, 32'd1);
            chk("t1_instr", instruction_o, 32'hA000_0000 | (i * 4));
            chk("t1_incr", pc_incr_o, (i * 4) + 4);
            chk("t1_addr", imem_addr_o, (i * 4) + 4);
        end

        // Ack delayed three cycles at 0x10.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            chk("t2_req", {31'd0, imem_req_o}, 32'd1);
            chk("t2_addr", imem_addr_o, 32'h10);
            chk("t2_valid", {31'd0, valid_o}, 32'd0);
        end
        cycle(0, 0, 0, 1);
        chk("t2_valid_after", {31'd0, valid_o}, 32'd1);
        chk("t2_instr", instruction_o, 32'hA000_0010);
        chk("t2_incr", pc_incr_o, 32'h14);

        // Stall with a response arriving: skid, then release.
        cycle(1, 0, 0, 1);
        chk("t3_req_drop", {31'd0, imem_req_o}, 32'd0);
        chk("t3_frozen", instruction_o, 32'hA000_0010);
        chk("t3_frozen_v", {31'd0, valid_o}, 32'd1);
        cycle(1, 0, 0, 0);
        chk("t3_still_frozen", instruction_o, 32'hA000_0010);
        cycle(0, 0, 0, 0);
        chk("t3_skid_instr", instruction_o, 32'hA000_0014);
        chk("t3_skid_incr", pc_incr_o, 32'h18);
        chk("t3_resume_req", {31'd0, imem_req_o}, 32'd1);
        chk("t3_resume_addr", imem_addr_o, 32'h18);

        // Redirect while 0x18 is pending; stale ack two cycles later.
        cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h200, 0);
        chk("t4_valid", {31'd0, valid_o}, 32'd0);
        chk("t4_old_addr", imem_addr_o, 32'h18);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        chk("t4_dropped", {31'd0, valid_o}, 32'd0);
        chk("t4_new_addr", imem_addr_o, 32'h200);
        cycle(0, 0, 0, 1);
        chk("t4_first", instruction_o, 32'hA000_0200);
        cycle(0, 1, 32'h200, 1);
        chk("t4b_valid", {31'd0, valid_o}, 32'd0);
        chk("t4b_addr", imem_addr_o, 32'h200);

        // Jump word at 0x100.
        cycle(0, 1, 32'h100, 1);
        chk("t6_addr", imem_addr_o, 32'h100);
        cycle(0, 0, 0, 1);
        chk("t6_instr", instruction_o, 32'h0800_0080);
        chk("t6_incr", pc_incr_o, 32'h104);
        chk("t6_jump", pc_jump_o, 32'h200);
`ifdef FETCH_JUMP_PREDECODE_EN
        chk("t6_next", imem_addr_o, 32'h200);
        chk("t6_pred", {31'd0, pred_jump_o}, 32'd1);
`else
        chk("t6_next", imem_addr_o, 32'h104);
        chk("t6_pred", {31'd0, pred_jump_o}, 32'd0);
`endif

        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFF8, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("wrap_instr", instruction_o, 32'hFFFF_FFFC);
        chk("wrap_incr", pc_incr_o, 32'h0);
        chk("wrap_addr", imem_addr_o, 32'h0);

        // Asynchronous reset in the middle of a pending request.
        cycle(0, 1, 32'h40, 1);
        chk("t5_addr", imem_addr_o, 32'h40);
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        imem_ack_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req", {31'd0, imem_req_o}, 32'd0);
        chk("t5_valid", {31'd0, valid_o}, 32'd0);
        chk("t5_addr_clr", imem_addr_o, 32'd0);
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem(32'h40);
        repeat (2) @(negedge clock);
        imem_ack_i = 1'b0;
        rst_n      = 1'b1;
        model_reset();
        cycle(0, 0, 0, 0);
        chk("t5_restart_addr", imem_addr_o, RESET_PC);
        chk("t5_restart_valid", {31'd0, valid_o}, 32'd0);
        cycle(0, 0, 0, 1);
        chk("t5_first", instruction_o, mem(RESET_PC));

        // Randomised traffic scored against the consumption stream.
        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            logic st, rd, ak;
            st = ($urandom_range(0, 99) < 30);
            ak = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 9))
                0:       rpc = 32'h100;
                1:       rpc = 32'hFFFF_FFF0;
                default: rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            cycle(st, rd, rpc, ak);
        end
        chk("progress", {31'd0, (consumed > 200)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
